// File: rtl/vga_timing_pkg.sv
// Shared types and 800x600@72 default timing constants for the VGA timing controller.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        ACT  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } phase_t;

    localparam int   DEF_H_VISIBLE = 800;
    localparam int   DEF_H_FP      = 56;
    localparam int   DEF_H_SYNC    = 120;
    localparam int   DEF_H_BP      = 64;
    localparam int   DEF_V_VISIBLE = 600;
    localparam int   DEF_V_FP      = 37;
    localparam int   DEF_V_SYNC    = 6;
    localparam int   DEF_V_BP      = 23;
    localparam logic DEF_SYNC_POL  = 1'b1;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_timing_ctrl_axis.sv
// One timing axis: wrapping position counter plus ACT/FP/SYNC/BP phase tracker.
// Exposes the next phase so the parent can register decodes aligned with the count.
module vga_axis_fsm
    import vga_timing_pkg::*;
#(
    parameter int P_VISIBLE = DEF_H_VISIBLE,
    parameter int P_FP      = DEF_H_FP,
    parameter int P_SYNC    = DEF_H_SYNC,
    parameter int P_BP      = DEF_H_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_count,
    output phase_t           o_phase_next,
    output logic             o_wrap
);

    localparam int TOTAL = P_VISIBLE + P_FP + P_SYNC + P_BP;

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] C_FP_AT   = CNT_W'(P_VISIBLE);
    localparam logic [CNT_W-1:0] C_SYNC_AT = CNT_W'(P_VISIBLE + P_FP);
    localparam logic [CNT_W-1:0] C_BP_AT   = CNT_W'(P_VISIBLE + P_FP + P_SYNC);

    generate
        if (TOTAL > (1 << CNT_W)) begin : g_total_check
            $error("vga_axis_fsm: axis total exceeds counter range");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    phase_t           r_phase;
    phase_t           w_phase_next;
    logic             w_wrap;

    // Phase changes are keyed on the count being entered, so phase and count stay aligned.
    always_comb begin
        w_wrap       = i_adv && (r_count == C_LAST);
        w_count_next = r_count;
        w_phase_next = r_phase;
        if (i_adv) begin
            w_count_next = w_wrap ? '0 : r_count + CNT_W'(1);
            if (w_count_next == '0)
                w_phase_next = ACT;
            else if (w_count_next == C_FP_AT)
                w_phase_next = FP;
            else if (w_count_next == C_SYNC_AT)
                w_phase_next = SYNC;
            else if (w_count_next == C_BP_AT)
                w_phase_next = BP;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_phase <= ACT;
        end else begin
            r_count <= w_count_next;
            r_phase <= w_phase_next;
        end
    end

    assign o_count      = r_count;
    assign o_phase_next = w_phase_next;
    assign o_wrap       = w_wrap;

endmodule

// File: rtl/vga_timing_ctrl.sv
// 800x600@72 VGA timing generator: counters, syncs, blank and line/frame strobes.
// Define VGA_PREFETCH_EN to add PIX_REQ/PIX_X/PIX_Y for a 1-cycle-latency frame buffer.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic SYNC_POL  = DEF_SYNC_POL
) (
    input  logic             CLKt,
    input  logic             RST,
    input  logic             EN,
    output logic [CNT_W-1:0] HCOUNT,
    output logic [CNT_W-1:0] VCOUNT,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             BLANK,
    output logic             LINE_START,
    output logic             FRAME_START
`ifdef VGA_PREFETCH_EN
    ,
    output logic             PIX_REQ,
    output logic [9:0]       PIX_X,
    output logic [9:0]       PIX_Y
`endif
);

    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    phase_t           w_h_phase_next;
    phase_t           w_v_phase_next;
    logic             w_h_wrap;
    logic             w_v_wrap;

    vga_axis_fsm #(
        .P_VISIBLE (H_VISIBLE),
        .P_FP      (H_FP),
        .P_SYNC    (H_SYNC),
        .P_BP      (H_BP)
    ) u_h_axis (
        .i_clk        (CLKt),
        .i_rst_n      (RST),
        .i_adv        (EN),
        .o_count      (w_hcount),
        .o_phase_next (w_h_phase_next),
        .o_wrap       (w_h_wrap)
    );

    vga_axis_fsm #(
        .P_VISIBLE (V_VISIBLE),
        .P_FP      (V_FP),
        .P_SYNC    (V_SYNC),
        .P_BP      (V_BP)
    ) u_v_axis (
        .i_clk        (CLKt),
        .i_rst_n      (RST),
        .i_adv        (w_h_wrap),
        .o_count      (w_vcount),
        .o_phase_next (w_v_phase_next),
        .o_wrap       (w_v_wrap)
    );

    logic r_hsync;
    logic r_vsync;
    logic r_blank;
    logic r_line_start;
    logic r_frame_start;

    // w_h_wrap already carries EN, so strobes fall to zero on any stalled cycle.
    always_ff @(posedge CLKt or negedge RST) begin
        if (!RST) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (w_h_phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_blank       <= (w_h_phase_next != ACT) || (w_v_phase_next != ACT);
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end
    end

    assign HCOUNT      = w_hcount;
    assign VCOUNT      = w_vcount;
    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign BLANK       = r_blank;
    assign LINE_START  = r_line_start;
    assign FRAME_START = r_frame_start;

`ifdef VGA_PREFETCH_EN
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_VIS_M1 = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] C_V_VIS    = CNT_W'(V_VISIBLE);

    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic [CNT_W-1:0] w_v_after;
    logic             w_req_next;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;
    logic             r_pix_req;
    logic [9:0]       r_pix_x;
    logic [9:0]       r_pix_y;

    // Request decode targets the pixel shown one enabled cycle after the count being entered.
    always_comb begin
        w_h_next  = w_h_wrap ? '0 : (EN ? w_hcount + CNT_W'(1) : w_hcount);
        w_v_next  = w_v_wrap ? '0 : (w_h_wrap ? w_vcount + CNT_W'(1) : w_vcount);
        w_v_after = (w_v_next == C_V_LAST) ? '0 : w_v_next + CNT_W'(1);
        if (w_h_next == C_H_LAST) begin
            w_req_next = (w_v_after < C_V_VIS);
            w_x_next   = 10'd0;
            w_y_next   = 10'(w_v_after);
        end else begin
            w_req_next = (w_h_next < C_H_VIS_M1) && (w_v_next < C_V_VIS);
            w_x_next   = 10'(w_h_next + CNT_W'(1));
            w_y_next   = 10'(w_v_next);
        end
    end

    // Reset values match the decode of position (0,0).
    always_ff @(posedge CLKt or negedge RST) begin
        if (!RST) begin
            r_pix_req <= 1'b1;
            r_pix_x   <= 10'd1;
            r_pix_y   <= 10'd0;
        end else begin
            r_pix_req <= w_req_next;
            r_pix_x   <= w_x_next;
            r_pix_y   <= w_y_next;
        end
    end

    assign PIX_REQ = r_pix_req;
    assign PIX_X   = r_pix_x;
    assign PIX_Y   = r_pix_y;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default horizontal timing, shortened vertical timing,
// outputs compared against a position model driven by a count of enabled cycles.
module tb_vga_timing_ctrl;
    import vga_timing_pkg::*;

    localparam int TB_V_VIS  = 8;
    localparam int TB_V_FP   = 2;
    localparam int TB_V_SYNC = 2;
    localparam int TB_V_BP   = 2;
    localparam int HT    = 1040;
    localparam int VT    = TB_V_VIS + TB_V_FP + TB_V_SYNC + TB_V_BP;
    localparam int HV    = 800;
    localparam int HS0   = 856;
    localparam int HS1   = 976;
    localparam int VS0   = TB_V_VIS + TB_V_FP;
    localparam int VS1   = VS0 + TB_V_SYNC;
    localparam int FRAME = HT * VT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        line_start;
    logic        frame_start;
`ifdef VGA_PREFETCH_EN
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    vga_timing_ctrl #(
        .V_VISIBLE (TB_V_VIS),
        .V_FP      (TB_V_FP),
        .V_SYNC    (TB_V_SYNC),
        .V_BP      (TB_V_BP)
    ) dut (
        .CLKt        (clk),
        .RST         (rst_n),
        .EN          (en),
        .HCOUNT      (hcount),
        .VCOUNT      (vcount),
        .HSYNC       (hsync),
        .VSYNC       (vsync),
        .BLANK       (blank),
        .LINE_START  (line_start),
        .FRAME_START (frame_start)
`ifdef VGA_PREFETCH_EN
        ,
        .PIX_REQ     (pix_req),
        .PIX_X       (pix_x),
        .PIX_Y       (pix_y)
`endif
    );

    // Reference: number of enabled clock edges since reset, and whether the last edge was enabled.
    int   m_t;
    logic m_last_en;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t       <= 0;
            m_last_en <= 1'b0;
        end else begin
            if (en) m_t <= m_t + 1;
            m_last_en <= en;
        end
    end

    function automatic int mh(int t);
        return t % HT;
    endfunction

    function automatic int mv(int t);
        return (t / HT) % VT;
    endfunction

    task automatic do_reset();
        en    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (hcount !== 11'd0) begin n_fail++; $display("FAIL reset_hcount: actual=%0d expected=0", hcount); end
        if (vcount !== 11'd0) begin n_fail++; $display("FAIL reset_vcount: actual=%0d expected=0", vcount); end
        if (hsync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: actual=%0b expected=0", hsync); end
        if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: actual=%0b expected=0", vsync); end
        if (blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: actual=%0b expected=0", blank); end
        if (line_start !== 1'b0) begin n_fail++; $display("FAIL reset_line_start: actual=%0b expected=0", line_start); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: actual=%0b expected=0", frame_start); end
        $display("test_reset: outputs sampled with RST held low");
    endtask

    task automatic test_line();
        int hs_cycles = 0;
        int ls_cycles = 0;
        logic [10:0] e_h;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= HT; i++) begin
            @(posedge clk);
            @(negedge clk);
            e_h = 11'(i % HT);
            n_checks += 4;
            if (hcount !== e_h) begin n_fail++; $display("FAIL line_hcount: i=%0d actual=%0d expected=%0d", i, hcount, e_h); end
            if (line_start !== (i == HT)) begin n_fail++; $display("FAIL line_strobe: i=%0d actual=%0b expected=%0b", i, line_start, (i == HT)); end
            if (i < HT) begin
                if (blank !== (i >= HV)) begin n_fail++; $display("FAIL line_blank: h=%0d actual=%0b expected=%0b", i, blank, (i >= HV)); end
                if (hsync !== (i >= HS0 && i < HS1)) begin n_fail++; $display("FAIL line_hsync: h=%0d actual=%0b", i, hsync); end
            end else begin
                if (blank !== 1'b0) begin n_fail++; $display("FAIL line_blank_wrap: actual=%0b expected=0", blank); end
                if (hsync !== 1'b0) begin n_fail++; $display("FAIL line_hsync_wrap: actual=%0b expected=0", hsync); end
            end
            if (hsync === 1'b1) hs_cycles++;
            if (line_start === 1'b1) ls_cycles++;
        end
        n_checks += 3;
        if (hs_cycles != HS1 - HS0) begin n_fail++; $display("FAIL line_hsync_width: actual=%0d expected=%0d", hs_cycles, HS1 - HS0); end
        if (ls_cycles != 1) begin n_fail++; $display("FAIL line_strobe_count: actual=%0d expected=1", ls_cycles); end
        if (vcount !== 11'd1) begin n_fail++; $display("FAIL line_vcount: actual=%0d expected=1", vcount); end
        $display("test_line: %0d cycles, hsync width %0d", HT, hs_cycles);
    endtask

    task automatic test_frame_random();
        int cyc = 0;
        int h;
        int v;
        int fs_count = 0;
        int fs_t = -1;
        int vs_cycles = 0;
        logic e_hs, e_vs, e_bl, e_ls, e_fs;
`ifdef VGA_PREFETCH_EN
        logic prev_blank = 1'b0;
        logic prev_req = 1'b0;
        logic e_req;
        int   e_x;
        int   e_y;
`endif
        do_reset();
        while (m_t < FRAME + 3 && cyc < 40000) begin
            en = ($urandom_range(0, 7) != 0);
            @(posedge clk);
            @(negedge clk);
            cyc++;
            h = mh(m_t);
            v = mv(m_t);
            e_hs = (h >= HS0 && h < HS1);
            e_vs = (v >= VS0 && v < VS1);
            e_bl = (h >= HV) || (v >= TB_V_VIS);
            e_ls = m_last_en && (h == 0);
            e_fs = e_ls && (v == 0);
            n_checks += 7;
            if (hcount !== 11'(h)) begin n_fail++; $display("FAIL frame_hcount: t=%0d actual=%0d expected=%0d", m_t, hcount, h); end
            if (vcount !== 11'(v)) begin n_fail++; $display("FAIL frame_vcount: t=%0d actual=%0d expected=%0d", m_t, vcount, v); end
            if (hsync !== e_hs) begin n_fail++; $display("FAIL frame_hsync: t=%0d actual=%0b expected=%0b", m_t, hsync, e_hs); end
            if (vsync !== e_vs) begin n_fail++; $display("FAIL frame_vsync: t=%0d actual=%0b expected=%0b", m_t, vsync, e_vs); end
            if (blank !== e_bl) begin n_fail++; $display("FAIL frame_blank: t=%0d actual=%0b expected=%0b", m_t, blank, e_bl); end
            if (line_start !== e_ls) begin n_fail++; $display("FAIL frame_line_start: t=%0d actual=%0b expected=%0b", m_t, line_start, e_ls); end
            if (frame_start !== e_fs) begin n_fail++; $display("FAIL frame_frame_start: t=%0d actual=%0b expected=%0b", m_t, frame_start, e_fs); end
            if (frame_start === 1'b1) begin fs_count++; fs_t = m_t; end
            if (vsync === 1'b1 && m_last_en) vs_cycles++;
`ifdef VGA_PREFETCH_EN
            if (h == HT - 1) begin
                e_y = (v + 1) % VT;
                e_req = (e_y < TB_V_VIS);
                e_x = 0;
            end else begin
                e_y = v;
                e_x = h + 1;
                e_req = (h < HV - 1) && (v < TB_V_VIS);
            end
            n_checks++;
            if (pix_req !== e_req) begin n_fail++; $display("FAIL frame_pix_req: t=%0d actual=%0b expected=%0b", m_t, pix_req, e_req); end
            if (e_req) begin
                n_checks += 2;
                if (pix_x !== 10'(e_x)) begin n_fail++; $display("FAIL frame_pix_x: t=%0d actual=%0d expected=%0d", m_t, pix_x, e_x); end
                if (pix_y !== 10'(e_y)) begin n_fail++; $display("FAIL frame_pix_y: t=%0d actual=%0d expected=%0d", m_t, pix_y, e_y); end
            end
            if (prev_blank === 1'b1 && blank === 1'b0) begin
                n_checks++;
                if (prev_req !== 1'b1) begin n_fail++; $display("FAIL frame_pix_lead: t=%0d actual=%0b expected=1", m_t, prev_req); end
            end
            prev_blank = blank;
            prev_req = pix_req;
`endif
        end
        n_checks += 4;
        if (cyc >= 40000) begin n_fail++; $display("FAIL frame_timeout: actual=%0d cycles expected<40000", cyc); end
        if (fs_count != 1) begin n_fail++; $display("FAIL frame_strobe_count: actual=%0d expected=1", fs_count); end
        if (fs_t != FRAME) begin n_fail++; $display("FAIL frame_strobe_time: actual=%0d expected=%0d", fs_t, FRAME); end
        if (vs_cycles != TB_V_SYNC * HT) begin n_fail++; $display("FAIL frame_vsync_width: actual=%0d expected=%0d", vs_cycles, TB_V_SYNC * HT); end
        $display("test_frame_random: %0d cycles, %0d enabled, vsync cycles %0d", cyc, m_t, vs_cycles);
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b1;
        repeat (HT - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks += 2;
        if (hcount !== 11'd1039) begin n_fail++; $display("FAIL stall_pre_hcount: actual=%0d expected=1039", hcount); end
        if (line_start !== 1'b0) begin n_fail++; $display("FAIL stall_pre_strobe: actual=%0b expected=0", line_start); end
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks += 4;
            if (hcount !== 11'd1039) begin n_fail++; $display("FAIL stall_hcount: i=%0d actual=%0d expected=1039", i, hcount); end
            if (vcount !== 11'd0) begin n_fail++; $display("FAIL stall_vcount: i=%0d actual=%0d expected=0", i, vcount); end
            if (line_start !== 1'b0) begin n_fail++; $display("FAIL stall_strobe: i=%0d actual=%0b expected=0", i, line_start); end
            if (blank !== 1'b1) begin n_fail++; $display("FAIL stall_blank: i=%0d actual=%0b expected=1", i, blank); end
        end
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (hcount !== 11'd0) begin n_fail++; $display("FAIL stall_wrap_hcount: actual=%0d expected=0", hcount); end
        if (vcount !== 11'd1) begin n_fail++; $display("FAIL stall_wrap_vcount: actual=%0d expected=1", vcount); end
        if (line_start !== 1'b1) begin n_fail++; $display("FAIL stall_wrap_strobe: actual=%0b expected=1", line_start); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks += 2;
            if (line_start !== 1'b0) begin n_fail++; $display("FAIL stall_post_strobe: i=%0d actual=%0b expected=0", i, line_start); end
            if (hcount !== 11'd0) begin n_fail++; $display("FAIL stall_post_hcount: i=%0d actual=%0d expected=0", i, hcount); end
        end
        $display("test_stall: 50-cycle stall at hcount 1039, wrap on first enabled cycle");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        en = 1'b1;
        repeat (VS0 * HT + 900) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks += 5;
        if (hcount !== 11'd900) begin n_fail++; $display("FAIL mid_pre_hcount: actual=%0d expected=900", hcount); end
        if (vcount !== 11'(VS0)) begin n_fail++; $display("FAIL mid_pre_vcount: actual=%0d expected=%0d", vcount, VS0); end
        if (hsync !== 1'b1) begin n_fail++; $display("FAIL mid_pre_hsync: actual=%0b expected=1", hsync); end
        if (vsync !== 1'b1) begin n_fail++; $display("FAIL mid_pre_vsync: actual=%0b expected=1", vsync); end
        if (blank !== 1'b1) begin n_fail++; $display("FAIL mid_pre_blank: actual=%0b expected=1", blank); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (hcount !== 11'd0) begin n_fail++; $display("FAIL mid_rst_hcount: actual=%0d expected=0", hcount); end
        if (vcount !== 11'd0) begin n_fail++; $display("FAIL mid_rst_vcount: actual=%0d expected=0", vcount); end
        if (hsync !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hsync: actual=%0b expected=0", hsync); end
        if (vsync !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vsync: actual=%0b expected=0", vsync); end
        if (blank !== 1'b0) begin n_fail++; $display("FAIL mid_rst_blank: actual=%0b expected=0", blank); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset_midframe: reset asserted between edges at hcount 900, vcount %0d", VS0);
    endtask

`ifdef VGA_PREFETCH_EN
    task automatic test_prefetch();
        do_reset();
        en = 1'b1;
        repeat (4 * HT + HT - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks += 5;
        if (hcount !== 11'd1039) begin n_fail++; $display("FAIL pf_hcount: actual=%0d expected=1039", hcount); end
        if (vcount !== 11'd4) begin n_fail++; $display("FAIL pf_vcount: actual=%0d expected=4", vcount); end
        if (pix_req !== 1'b1) begin n_fail++; $display("FAIL pf_req: actual=%0b expected=1", pix_req); end
        if (pix_x !== 10'd0) begin n_fail++; $display("FAIL pf_x: actual=%0d expected=0", pix_x); end
        if (pix_y !== 10'd5) begin n_fail++; $display("FAIL pf_y: actual=%0d expected=5", pix_y); end
        $display("test_prefetch: request point at hcount 1039, vcount 4");
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame_random();
        test_stall();
        test_reset_midframe();
`ifdef VGA_PREFETCH_EN
        test_prefetch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the 800x600@72 Hz pixel timing at 50 MHz, one pixel per CLKt.
- Owns the horizontal counter (0..1039) and the vertical counter (0..665), which advances on each horizontal wrap.
- Decodes both counts into HSYNC, VSYNC, BLANK and line/frame strobes for the pixel pipeline and DAC pins.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels); line total 1040
- V_VISIBLE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines); frame total 666
- SYNC_POL, 1, active level of HSYNC/VSYNC (1 = positive, as VESA 800x600@72)

Ports:
- CLKt, in, 1, pixel clock, 50 MHz
- RST, in, 1, asynchronous active-low reset
- EN, in, 1, count enable; low freezes all state and outputs
- HCOUNT, out, 11, horizontal position 0..1039
- VCOUNT, out, 11, vertical position 0..665
- HSYNC, out, 1, horizontal sync at SYNC_POL level
- VSYNC, out, 1, vertical sync at SYNC_POL level
- BLANK, out, 1, high outside the 800x600 visible window
- LINE_START, out, 1, one-cycle strobe when HCOUNT wraps to 0
- FRAME_START, out, 1, one-cycle strobe when both counters wrap to 0

Behaviour:
- All outputs are registered. Sync and blank decodes are computed from next-count values, so every output is cycle-aligned with the HCOUNT/VCOUNT it describes. There is no extra latency.
- Reset (RST=0, asynchronous):
  - HCOUNT=0, VCOUNT=0, BLANK=0, LINE_START=0, FRAME_START=0.
  - HSYNC and VSYNC drive the inactive level (~SYNC_POL).
  - Both phase FSMs go to ACT.
- Release is synchronous to the next CLKt edge.
- Horizontal counting, with EN=1:
  - HCOUNT increments each cycle.
  - At 1039 (H_TOTAL-1) it wraps to 0, LINE_START=1 for that cycle, and VCOUNT advances.
- Vertical counting: VCOUNT wraps from 665 to 0 only on a horizontal wrap; FRAME_START=1 in that same cycle.
- Phase FSM per axis, states ACT -> FP -> SYNC -> BP -> ACT:
  - H transitions when HCOUNT reaches 800, 856, 976, and wraps to 0.
  - V transitions when VCOUNT reaches 600, 637, 643, and wraps to 0.
  - The V FSM evaluates only on horizontal wrap.
- Decodes:
  - HSYNC active when H state = SYNC, i.e. HCOUNT 856..975.
  - VSYNC active when V state = SYNC, i.e. VCOUNT 637..642.
  - BLANK = (H state != ACT) | (V state != ACT).
- EN=0: counters, FSMs and level outputs hold their values. LINE_START and FRAME_START drop to 0, and a strobe never repeats across a stall.
- Strobes are not issued out of reset. The first LINE_START comes 1040 enabled cycles after release; the first FRAME_START comes 692640 cycles after release.
- Reset mid-frame aborts immediately to the reset state; no partial sync pulse is stretched.
- Widths: counters are 11 bits. Elaboration checks that H and V totals are <= 2048.

Optional Feature:
- Macro VGA_PREFETCH_EN.
- When defined:
  - Adds output PIX_REQ (1 bit), asserted one cycle before each visible pixel: HCOUNT 1039 or 0..798, qualified by the next line being visible.
  - Adds PIX_X and PIX_Y (10 bits each), the coordinates of the pixel to fetch.
  - This lets a 1-cycle-latency frame buffer deliver data aligned with BLANK=0.
- When undefined: these ports and their logic do not exist, and behaviour is otherwise identical.

Decomposition:
- Package vga_timing_pkg holds:
  - phase enum {ACT, FP, SYNC, BP}
  - 800x600@72 default constants, with derived H_TOTAL=1040 and V_TOTAL=666
  - counter width constant 11
- Sub-module vga_axis_fsm: a parameterised counter plus phase FSM with an advance input and a wrap output. It is instanced twice, H advanced by EN and V advanced by H wrap.

Test Plan:
- Reset release, EN=1, 1040 cycles -> HCOUNT 0..1039 then 0; LINE_START high only at the wrap cycle; VCOUNT=1.
- Sample line 0 -> BLANK=0 for HCOUNT 0..799 and 1 for 800..1039; HSYNC=1 exactly for HCOUNT 856..975 (120 cycles).
- Run a full frame -> VSYNC=1 for VCOUNT 637..642 (6 lines = 6240 cycles); FRAME_START single pulse after 692640 cycles, with HCOUNT=VCOUNT=0.
- EN low for 50 cycles at HCOUNT=1039 -> everything holds, no LINE_START; wrap and strobe occur on the first enabled cycle.
- Assert RST at HCOUNT=900, VCOUNT=640 -> HSYNC, VSYNC, counters and BLANK reach reset values without waiting for a clock edge.
- With VGA_PREFETCH_EN: PIX_REQ leads BLANK falling by exactly 1 cycle on each visible line; PIX_X=0, PIX_Y=5 at HCOUNT=1039, VCOUNT=4.
